// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, legal-code bound and link sync nibble shared
// by dir_link and its byte codec.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_t;

    // Highest legal direction code; 5..7 are malformed on the link.
    localparam logic [2:0] DIR_MAX  = 3'd4;
    // Upper nibble that marks a direction byte on the serial link.
    localparam logic [3:0] SYNC_NIB = 4'hA;

    // 180-degree opposite of a direction; NONE has no opposite.
    function automatic dir_t dir_reverse(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_RIGHT: return DIR_LEFT;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dir_link_if.sv
// dir_link_if: UART-side byte handshake of dir_link.
// master = UART side (drives received bytes and tx_ready),
// slave  = dir_link (drives the outgoing direction byte).
interface dir_link_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/dir_codec.sv
// dir_codec: builds the canonical link byte for the direction in byte_in[2:0]
// and validates byte_in as a received link byte.
// DIR_LINK_PARITY_EN: when defined, bit 3 carries P = 1 when the direction
// bits hold an even number of ones, and received bytes must match it.
// Undefined: P is sent as 0 and received bit 3 is ignored.
module dir_codec
    import snake_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out,
    output dir_t       dir_out,
    output logic       ok
);
    logic p_calc;
    logic p_ok;

`ifdef DIR_LINK_PARITY_EN
    assign p_calc = ~^byte_in[2:0];
    assign p_ok   = (byte_in[3] == p_calc);
`else
    logic bit3_unused;
    assign bit3_unused = byte_in[3];
    assign p_calc      = 1'b0;
    assign p_ok        = 1'b1;
`endif

    assign byte_out = {SYNC_NIB, p_calc, byte_in[2:0]};
    assign dir_out  = dir_t'(byte_in[2:0]);
    assign ok       = (byte_in[7:4] == SYNC_NIB) && (byte_in[2:0] <= DIR_MAX) && p_ok;

endmodule

// File: rtl/dir_link.sv
// dir_link: samples local keys into a pending direction, commits it on each
// game tick, sends it as a link byte, and accepts the remote direction byte.
// Parity on the link byte is enabled by defining DIR_LINK_PARITY_EN.
module dir_link
    import snake_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clk_div,
    input  logic      btn_up,
    input  logic      btn_down,
    input  logic      btn_right,
    input  logic      btn_left,
    dir_link_if.slave bus,
    output dir_t      dir1,
    output dir_t      dir2,
    output logic      rcvdir,
    output logic      frame_err,
    output logic      tx_overrun
);
    logic       clk_div_q;
    logic       tick;
    dir_t       pending;
    dir_t       key_dir;
    dir_t       dir1_nxt;
    logic [7:0] tx_byte;
    dir_t       tx_dir_unused;
    logic       tx_ok_unused;
    logic [7:0] rx_byte_unused;
    dir_t       rx_dir;
    logic       rx_ok;

    assign tick = clk_div & ~clk_div_q;

    // Resolve simultaneous keys by fixed priority UP > DOWN > RIGHT > LEFT.
    always_comb begin
        key_dir = DIR_NONE;
        if (btn_up)         key_dir = DIR_UP;
        else if (btn_down)  key_dir = DIR_DOWN;
        else if (btn_right) key_dir = DIR_RIGHT;
        else if (btn_left)  key_dir = DIR_LEFT;
    end

    // Value dir1 takes this cycle: a non-NONE pending commits on a tick.
    always_comb begin
        dir1_nxt = dir1;
        if (tick && pending != DIR_NONE) dir1_nxt = pending;
    end

    dir_codec u_tx_codec (
        .byte_in  ({SYNC_NIB, 1'b0, dir1_nxt}),
        .byte_out (tx_byte),
        .dir_out  (tx_dir_unused),
        .ok       (tx_ok_unused)
    );

    dir_codec u_rx_codec (
        .byte_in  (bus.rx_data),
        .byte_out (rx_byte_unused),
        .dir_out  (rx_dir),
        .ok       (rx_ok)
    );

    // Local direction: tick edge detect, commit, then load pending. Keys are
    // checked against the post-commit dir1 so a key in the tick cycle can
    // never schedule a reversal for the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_div_q <= 1'b0;
            dir1      <= DIR_NONE;
            pending   <= DIR_NONE;
        end else begin
            clk_div_q <= clk_div;
            dir1      <= dir1_nxt;
            if (key_dir != DIR_NONE && key_dir != dir_reverse(dir1_nxt))
                pending <= key_dir;
            else if (tick)
                pending <= DIR_NONE;
        end
    end

    // Transmit holding register: a tick always loads the newest byte; a tick
    // that lands on a still-unaccepted byte is flagged as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_data  <= 8'h00;
            bus.tx_valid <= 1'b0;
            tx_overrun   <= 1'b0;
        end else if (tick) begin
            bus.tx_data  <= tx_byte;
            bus.tx_valid <= 1'b1;
            if (bus.tx_valid && !bus.tx_ready) tx_overrun <= 1'b1;
        end else if (bus.tx_valid && bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
        end
    end

    // Receive: accepted bytes refresh dir2 with a one-cycle rcvdir pulse,
    // malformed ones set the sticky frame error.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir2      <= DIR_NONE;
            rcvdir    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rcvdir <= bus.rx_valid && rx_ok;
            if (bus.rx_valid) begin
                if (rx_ok) dir2      <= rx_dir;
                else       frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dir_link.sv
// tb_dir_link: directed steps followed by random traffic, every cycle checked
// against a behavioural model of the direction link.
module tb_dir_link;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst, clk_div, btn_up, btn_down, btn_right, btn_left;
    dir_t dir1, dir2;
    logic rcvdir, frame_err, tx_overrun;

    dir_link_if bus ();

    dir_link u_dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_right  (btn_right),
        .btn_left   (btn_left),
        .bus        (bus.slave),
        .dir1       (dir1),
        .dir2       (dir2),
        .rcvdir     (rcvdir),
        .frame_err  (frame_err),
        .tx_overrun (tx_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int m_dir1, m_dir2, m_pend, m_rcv, m_txv, m_txd, m_ferr, m_ovr, m_cdq;
    int opp[5] = '{0, 2, 1, 4, 3};

    function automatic int par_bit(int d);
`ifdef DIR_LINK_PARITY_EN
        int ones = (d & 1) + ((d >> 1) & 1) + ((d >> 2) & 1);
        return (ones % 2 == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int enc(int d);
        return 160 + 8 * par_bit(d) + d;
    endfunction

    function automatic bit accept(int b);
        bit ok = ((b >> 4) == 10) && ((b & 7) <= 4);
`ifdef DIR_LINK_PARITY_EN
        ok = ok && (((b >> 3) & 1) == par_bit(b & 7));
`endif
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int tk, nd1, k;
        if (rst) begin
            m_dir1 = 0; m_dir2 = 0; m_pend = 0; m_rcv = 0; m_txv = 0;
            m_txd = 0; m_ferr = 0; m_ovr = 0; m_cdq = 0;
        end else begin
            tk  = (clk_div && m_cdq == 0) ? 1 : 0;
            nd1 = (tk != 0 && m_pend != 0) ? m_pend : m_dir1;
            k   = btn_up ? 1 : btn_down ? 2 : btn_right ? 3 : btn_left ? 4 : 0;
            if (tk != 0) begin
                if (m_txv != 0 && !bus.tx_ready) m_ovr = 1;
                m_txd = enc(nd1);
                m_txv = 1;
            end else if (m_txv != 0 && bus.tx_ready) begin
                m_txv = 0;
            end
            if (k != 0 && k != opp[nd1]) m_pend = k;
            else if (tk != 0)            m_pend = 0;
            m_dir1 = nd1;
            m_rcv  = 0;
            if (bus.rx_valid) begin
                if (accept(int'(bus.rx_data))) begin
                    m_dir2 = int'(bus.rx_data) & 7;
                    m_rcv  = 1;
                end else begin
                    m_ferr = 1;
                end
            end
            m_cdq = clk_div ? 1 : 0;
        end
    endtask

    task automatic check_all();
        chk("dir1",       {5'b0, dir1},         8'(m_dir1));
        chk("dir2",       {5'b0, dir2},         8'(m_dir2));
        chk("rcvdir",     {7'b0, rcvdir},       8'(m_rcv));
        chk("tx_valid",   {7'b0, bus.tx_valid}, 8'(m_txv));
        chk("tx_data",    bus.tx_data,          8'(m_txd));
        chk("frame_err",  {7'b0, frame_err},    8'(m_ferr));
        chk("tx_overrun", {7'b0, tx_overrun},   8'(m_ovr));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic keys(input logic u, input logic d, input logic r, input logic l);
        btn_up = u; btn_down = d; btn_right = r; btn_left = l;
    endtask

    initial begin
        rst = 1'b1; clk_div = 1'b0; keys(0, 0, 0, 0);
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
        m_dir1 = 0; m_dir2 = 0; m_pend = 0; m_rcv = 0; m_txv = 0;
        m_txd = 0; m_ferr = 0; m_ovr = 0; m_cdq = 0;

        // reset state
        cyc(); cyc();
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_dir1", {5'b0, dir1}, 8'h00);
        rst = 1'b0;
        cyc();

        // first tick after reset with no key
        clk_div = 1'b1; cyc();
        chk("first_tick_byte", bus.tx_data, enc(0));
`ifndef DIR_LINK_PARITY_EN
        chk("first_tick_a0", bus.tx_data, 8'hA0);
`endif
        bus.tx_ready = 1'b1; cyc();
        chk("handshake_drop", {7'b0, bus.tx_valid}, 8'h00);
        bus.tx_ready = 1'b0;

        // RIGHT then tick
        clk_div = 1'b0; keys(0, 0, 1, 0); cyc();
        keys(0, 0, 0, 0); cyc();
        clk_div = 1'b1; cyc();
        chk("right_dir1", {5'b0, dir1}, 8'h03);
`ifdef DIR_LINK_PARITY_EN
        chk("right_byte", bus.tx_data, 8'hAB);
`else
        chk("right_byte", bus.tx_data, 8'hA3);
`endif
        chk("right_valid", {7'b0, bus.tx_valid}, 8'h01);
        bus.tx_ready = 1'b1; cyc(); bus.tx_ready = 1'b0;

        // UP, then held DOWN is a reversal and is ignored
        clk_div = 1'b0; keys(1, 0, 0, 0); cyc();
        keys(0, 0, 0, 0); clk_div = 1'b1; cyc();
        chk("up_dir1", {5'b0, dir1}, 8'h01);
        keys(0, 1, 0, 0); clk_div = 1'b0; cyc();
        clk_div = 1'b1; cyc();
        chk("rev_dir1", {5'b0, dir1}, 8'h01);
        chk("rev_low_bits", {5'b0, bus.tx_data[2:0]}, 8'h01);
        keys(0, 0, 0, 0);

        // second tick with byte still unaccepted -> overrun
        clk_div = 1'b0; keys(0, 0, 0, 1); cyc();
        keys(0, 0, 0, 0); clk_div = 1'b1; cyc();
        chk("ovr_flag", {7'b0, tx_overrun}, 8'h01);
        chk("ovr_byte", bus.tx_data, 8'hA4);
        bus.tx_ready = 1'b1; cyc(); bus.tx_ready = 1'b0;
        chk("ovr_drain", {7'b0, bus.tx_valid}, 8'h00);

        // remote bytes
        bus.rx_data = 8'hA4; bus.rx_valid = 1'b1; cyc();
        chk("rx_left", {5'b0, dir2}, 8'h04);
        chk("rx_pulse", {7'b0, rcvdir}, 8'h01);
        bus.rx_valid = 1'b0; cyc();
        chk("rx_pulse_end", {7'b0, rcvdir}, 8'h00);
        bus.rx_data = 8'hB1; bus.rx_valid = 1'b1; cyc();
        chk("bad_sync_err", {7'b0, frame_err}, 8'h01);
        chk("bad_sync_dir2", {5'b0, dir2}, 8'h04);
        bus.rx_valid = 1'b0;

        // rx and tick together
        clk_div = 1'b0; cyc();
        clk_div = 1'b1; bus.rx_data = 8'hA2; bus.rx_valid = 1'b1; cyc();
        chk("both_rcvdir", {7'b0, rcvdir}, 8'h01);
        chk("both_txv", {7'b0, bus.tx_valid}, 8'h01);
        bus.rx_valid = 1'b0;

        // reset with a byte pending, then illegal code 7
        rst = 1'b1; cyc();
        chk("rst_drop_txv", {7'b0, bus.tx_valid}, 8'h00);
        chk("rst_ferr", {7'b0, frame_err}, 8'h00);
        rst = 1'b0; clk_div = 1'b0; cyc();
        bus.rx_data = 8'hA7; bus.rx_valid = 1'b1; cyc();
        chk("illegal_err", {7'b0, frame_err}, 8'h01);
        chk("illegal_nopulse", {7'b0, rcvdir}, 8'h00);
        bus.rx_valid = 1'b0;
        rst = 1'b1; cyc();
        chk("rst2_dir2", {5'b0, dir2}, 8'h00);
        chk("rst2_ferr", {7'b0, frame_err}, 8'h00);
        rst = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) clk_div = ~clk_div;
            btn_up    = ($urandom_range(0, 7) == 0);
            btn_down  = ($urandom_range(0, 7) == 0);
            btn_right = ($urandom_range(0, 7) == 0);
            btn_left  = ($urandom_range(0, 7) == 0);
            bus.tx_ready = ($urandom_range(0, 2) == 0);
            bus.rx_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0)
                bus.rx_data = {4'hA, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4))};
            else
                bus.rx_data = 8'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dir_link.md
DIR_LINK -- requirements
Module: dir_link

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 clk_div  input  1  game tick level; a tick is a sampled 0->1 transition.
REQ-004 btn_up, btn_down, btn_right, btn_left  input  1 each  debounced local key levels.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 tx_ready  input  1  UART transmitter can accept a byte.
REQ-008 dir1  output  direction  committed local direction, to move stage.
REQ-009 dir2  output  direction  last valid remote direction, to move stage.
REQ-010 rcvdir  output  1  one-cycle pulse: dir2 refreshed.
REQ-011 tx_data  output  8  encoded local direction byte.
REQ-012 tx_valid  output  1  tx_data pending, held until accepted.
REQ-013 frame_err  output  1  sticky: malformed remote byte received.
REQ-014 tx_overrun  output  1  sticky: tick occurred while previous byte unaccepted.

Function
REQ-015 Direction codes SHALL be 3 bits: NONE=0, UP=1, DOWN=2, RIGHT=3, LEFT=4; codes 5-7 illegal.
REQ-016 Key sampling SHALL resolve simultaneous keys by priority UP > DOWN > RIGHT > LEFT into a pending register each cycle.
REQ-017 A key whose direction is the 180-degree reverse of current dir1 SHALL be ignored; pending is unchanged.
REQ-018 With no key asserted, pending SHALL hold its value.
REQ-019 Tick detection SHALL register clk_div and flag a tick in the cycle where the registered value is 0 and clk_div is 1.
REQ-020 In the cycle after a tick, dir1 SHALL equal pending if pending != NONE, else keep its previous value; pending SHALL clear to NONE in that same cycle.
REQ-021 A key press in the tick cycle SHALL load pending after the commit and apply to the next tick.
REQ-022 In the cycle after a tick, tx_data SHALL be {4'hA, P, dir1_new} and tx_valid SHALL assert.
REQ-023 tx_valid SHALL remain high, tx_data stable, until a cycle with tx_valid and tx_ready both high; it deasserts in the following cycle.
REQ-024 A tick while tx_valid is still high SHALL replace tx_data with the new byte, keep tx_valid high, and set tx_overrun.
REQ-025 On rx_valid, byte accepted iff rx_data[7:4]==4'hA, rx_data[2:0] <= 4, and parity check passes (REQ-033).
REQ-026 An accepted byte SHALL update dir2 and pulse rcvdir for exactly one cycle, both in the cycle after rx_valid.
REQ-027 A rejected byte SHALL leave dir2 unchanged, not pulse rcvdir, and set frame_err.
REQ-028 Receive and transmit paths SHALL operate independently; rx_valid coincident with a tick processes both.
REQ-029 Sticky flags SHALL clear only on rst.

Reset
REQ-030 On rst: dir1=NONE, dir2=NONE, pending=NONE, rcvdir=0, tx_valid=0, tx_data=8'h00, frame_err=0, tx_overrun=0, registered clk_div=0.
REQ-031 rst asserted with tx_valid high SHALL drop the pending byte without handshake.
REQ-032 The first tick after reset with no key pressed SHALL transmit 8'hA0.

Configuration
REQ-033 With DIR_LINK_PARITY_EN defined: P = even parity of dir bits[2:0]; receive rejects on mismatch of rx_data[3]. Undefined: P=0 transmitted; rx_data[3] ignored.

Structure
REQ-034 direction enum, illegal-code bound, sync nibble 4'hA SHALL reside in snake_pkg.
REQ-035 Byte encode/validate logic SHALL be one sub-module dir_codec, instanced for tx encode and rx decode.

Verification
REQ-036 Press RIGHT, tick -> next cycle dir1=RIGHT, tx_data=8'hA3 (8'hAB with parity), tx_valid=1.
REQ-037 dir1=UP, hold btn_down, tick -> dir1 stays UP, tx_data low bits=001.
REQ-038 tx_ready=0 across two ticks -> tx_overrun=1, tx_data holds second byte; tx_ready=1 -> tx_valid=0 next cycle.
REQ-039 rx_data=8'hA4 with rx_valid -> dir2=LEFT, rcvdir one-cycle pulse; rx_data=8'hB1 -> frame_err=1, dir2=LEFT.
REQ-040 rx_data=8'hA7 -> rejected, frame_err=1; then rst -> all outputs per REQ-030.
REQ-041 rx_valid and tick same cycle -> rcvdir pulse and tx_valid rise in the same following cycle.
